// File: rtl/tdc_readout_fifo.sv
// TDC readout write-side responder: frames parallel-loaded counter words into
// header/data/trailer event records and buffers them in a synchronous FIFO.
module tdc_readout_fifo #(
  parameter int DEPTH = 64,
  parameter int NCH   = 32
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        start,
  input  logic        ld,
  input  logic [19:0] din,
  input  logic        rden,
  output logic [31:0] dout,
  output logic        dvalid,
  output logic        empty,
  output logic        full,
  output logic        ovf,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [7:0]  LAST_CH  = 8'(NCH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_TRL  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  // Framer state
  state_t      r_state, w_state_nxt;
  logic [7:0]  r_ch, w_ch_nxt;
  logic [15:0] r_evt, w_evt_nxt;
  logic        r_err, w_err_nxt;
  logic        w_wr_req;
  logic [31:0] w_wr_word;

  // FIFO state
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count, w_count_nxt;
  logic          r_empty, r_full, r_ovf, r_dvalid;
  logic [31:0]   r_dout;
  logic          w_do_wr, w_do_rd;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_evt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_evt   <= w_evt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Dropping start in LOAD wins over a coincident ld: that word is not written.
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_evt_nxt   = r_evt;
    w_err_nxt   = r_err;
    w_wr_req    = 1'b0;
    w_wr_word   = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_wr_req    = 1'b1;
          w_wr_word   = {4'hA, 12'h000, r_evt};
          w_ch_nxt    = '0;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!start) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_TRL;
        end else if (ld) begin
          w_wr_req  = 1'b1;
          w_wr_word = {4'h1, 3'b000, r_ch[4:0], din};
          w_ch_nxt  = r_ch + 8'd1;
          if (w_ch_nxt == LAST_CH) begin
            w_state_nxt = S_TRL;
          end
        end
      end
      S_TRL: begin
        w_wr_req    = 1'b1;
        w_wr_word   = {4'hF, 3'b000, r_err, r_evt[7:0], 8'h00, r_ch};
        w_evt_nxt   = r_evt + 16'd1;
        w_err_nxt   = 1'b0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!start) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Full is judged on the registered flag, before any same-cycle read.
  assign w_do_wr     = w_wr_req & ~r_full;
  assign w_do_rd     = rden & ~r_empty;
  assign w_count_nxt = r_count + {{AW{1'b0}}, w_do_wr} - {{AW{1'b0}}, w_do_rd};

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= w_wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
      r_dvalid <= 1'b0;
      r_dout   <= '0;
    end else begin
      r_count  <= w_count_nxt;
      r_empty  <= (w_count_nxt == '0);
      r_full   <= (w_count_nxt == FULL_CNT);
      r_dvalid <= w_do_rd;
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_dout   <= r_mem[r_rd_ptr];
      end
      if (w_wr_req && r_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign dout      = r_dout;
  assign dvalid    = r_dvalid;
  assign empty     = r_empty;
  assign full      = r_full;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tdc_readout_fifo.sv
// Bench for tdc_readout_fifo: a table of event records drives the framer while
// a scoreboard queue holds the words expected out of the FIFO, in order.
module tb_tdc_readout_fifo;

  localparam int DEPTH = 64;
  localparam int NCH   = 32;

  logic        clk = 1'b0;
  logic        clr_n, start, ld, rden;
  logic [19:0] din;
  logic [31:0] dout;
  logic        dvalid, empty, full, ovf;
  logic [1:0]  dbg_state;

  tdc_readout_fifo #(.DEPTH(DEPTH), .NCH(NCH)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .ld(ld), .din(din), .rden(rden),
    .dout(dout), .dvalid(dvalid), .empty(empty), .full(full), .ovf(ovf),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pop    = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_dout   = '0;
  logic [15:0] m_evt    = '0;
  int          m_stored = 0;
  bit          m_limit  = 1'b0;
  int          rd_mode  = 0;

  // pre: 0 none, 2 preload evt=FFFF, 3 begin no-read overflow fill
  // post: 0 none, 1 drain, 2 overflow flag checks then drain
  typedef struct {
    int          n_ld;
    int          gap;
    bit          abort;
    int          rd_mode;
    int          pre;
    int          post;
    logic [31:0] exp_trl;
  } ev_t;
  ev_t ev_tab[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    if (m_limit && m_stored >= DEPTH) return;
    exp_q.push_back(w);
    m_stored++;
  endtask

  // Reader: 0 idle, 1 rden held high, 2 rden toggles every cycle
  initial begin
    rden = 1'b0;
    forever begin
      @(negedge clk);
      case (rd_mode)
        1:       rden = 1'b1;
        2:       rden = ~rden;
        default: rden = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor: every dvalid pops one expected word; otherwise dout holds.
  always @(negedge clk) begin
    if (!clr_n) begin
      m_dout = '0;
    end else if (dvalid) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got %h expected no word at %0t", dout, $time);
      end else begin
        m_dout = exp_q.pop_front();
        check("rd_word", dout, m_dout);
      end
    end else begin
      check("dout_hold", dout, m_dout);
    end
  end

  task automatic drain();
    rd_mode = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (empty) break;
    end
    rd_mode = 0;
    repeat (2) @(negedge clk);
    check("drain_left", exp_q.size(), 0);
    check("drain_empty", empty, 1'b1);
  endtask

  task automatic run_event(input ev_t e);
    @(negedge clk);
    rd_mode = e.rd_mode;
    start = 1'b1;
    push_word({4'hA, 12'h000, m_evt});
    @(negedge clk);
    for (int i = 0; i < e.n_ld; i++) begin
      ld  = 1'b1;
      din = 20'h00100 + 20'(i);
      push_word({4'h1, 3'b000, 5'(i), din});
      if (!e.abort && i == e.n_ld - 1) push_word(e.exp_trl);
      @(negedge clk);
      ld = 1'b0;
      repeat (e.gap) @(negedge clk);
    end
    if (e.abort) begin
      push_word(e.exp_trl);
      start = 1'b0;
      ld    = 1'b1;
      din   = 20'hABCDE;
      @(negedge clk);
      ld = 1'b0;
      @(negedge clk);
    end else begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    m_evt = m_evt + 16'd1;
  endtask

  initial begin
    int pop_base;
    ev_tab[0] = '{5,  0, 1'b1, 0, 0, 1, 32'hF100_0005};
    ev_tab[1] = '{32, 0, 1'b0, 0, 0, 1, 32'hF001_0020};
    ev_tab[2] = '{32, 2, 1'b0, 2, 0, 1, 32'hF002_0020};
    ev_tab[3] = '{32, 0, 1'b0, 0, 3, 0, 32'hF003_0020};
    ev_tab[4] = '{32, 0, 1'b0, 0, 0, 2, 32'hF004_0020};
    ev_tab[5] = '{32, 0, 1'b0, 1, 2, 0, 32'hF0FF_0020};
    ev_tab[6] = '{32, 0, 1'b0, 1, 0, 0, 32'hF000_0020};
    ev_tab[7] = '{32, 0, 1'b0, 1, 0, 1, 32'hF001_0020};

    clr_n = 1'b0;
    start = 1'b0;
    ld    = 1'b0;
    din   = '0;
    repeat (2) @(negedge clk);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_dvalid", dvalid, 1'b0);
    check("rst_dout", dout, 32'h0);
    check("rst_state", dbg_state, 2'd0);
    clr_n = 1'b1;

    // Reads on an empty FIFO pop nothing
    rd_mode = 2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("empty_rd_dvalid", dvalid, 1'b0);
      check("empty_rd_dout", dout, 32'h0);
    end
    rd_mode = 0;
    @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      if (ev_tab[k].pre == 2) begin
        @(negedge clk);
        force dut.r_evt = 16'hFFFF;
        @(negedge clk);
        release dut.r_evt;
        m_evt = 16'hFFFF;
      end else if (ev_tab[k].pre == 3) begin
        m_stored = 0;
        m_limit  = 1'b1;
      end
      run_event(ev_tab[k]);
      if (ev_tab[k].post == 2) begin
        check("ovf_full", full, 1'b1);
        check("ovf_flag", ovf, 1'b1);
        check("ovf_queued", exp_q.size(), DEPTH);
        m_limit  = 1'b0;
        pop_base = n_pop;
        drain();
        check("ovf_drain_cnt", n_pop - pop_base, DEPTH);
        check("ovf_sticky", ovf, 1'b1);
        check("ovf_full_clr", full, 1'b0);
      end else if (ev_tab[k].post == 1) begin
        drain();
        check("post_ovf", ovf, (k < 4) ? 1'b0 : 1'b1);
      end
    end

    clr_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    check("final_rst_ovf", ovf, 1'b0);
    check("final_rst_empty", empty, 1'b1);
    check("final_rst_dout", dout, 32'h0);
    clr_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdc_readout_fifo.md
# tdc_readout_fifo

Write-side responder for the TDC readout test path. It frames the 32 parallel-loaded TDC counter words into a header / data / trailer event record and buffers the record in a synchronous FIFO. It presents `empty`, and returns one word per `rden` to the readout state machine that drives `start`, `ld` and `rden`. It sits between the TDC counter bank and the readout hardware.

## Interface
- `DEPTH`, 64: FIFO depth in 32-bit words; power of two, at least 64.
- `NCH`, 32: data words per event; range 1–32.
- `clk` in 1: single clock, rising edge.
- `clr_n` in 1: synchronous, active-low reset.
- `start` in 1: run enable. A level; dropping it aborts the current event.
- `ld` in 1: load strobe. One counter word per cycle while high.
- `din` in 20: counter value, sampled when `ld`=1.
- `rden` in 1: FIFO read request.
- `dout` out 32: read data, registered.
- `dvalid` out 1: `dout` holds a newly read word (one-cycle pulse).
- `empty` out 1: FIFO holds no words.
- `full` out 1: FIFO holds `DEPTH` words.
- `ovf` out 1: sticky overflow flag. Cleared only by `clr_n`=0.

## Operation
- **Framer states:** IDLE, LOAD, TRL, WAIT.
- **IDLE**
  - When `start`=1: write the header `{4'hA, 12'h000, evt[15:0]}`.
  - Then: ch←0, state→LOAD.
- **LOAD**
  - Each cycle with `ld`=1: write `{4'h1, 3'b000, ch[4:0], din[19:0]}`, then ch←ch+1.
  - When the `NCH`-th word is written: state→TRL.
  - `ld`=0 cycles write nothing.
  - If `start`=0 (takes priority over `ld`): err←1, state→TRL. No data word is written that cycle.
- **TRL**
  - Write the trailer `{4'hF, 3'b000, err, evt[7:0], 8'h00, ch[7:0]}`, where `ch` is the number of data words written.
  - Then: evt←evt+1 (16-bit, wraps at 0xFFFF→0), err←0, state→WAIT.
- **WAIT:** when `start`=0, state→IDLE.
  - A new event always needs `start` to go low and then high again.
- **Ignored `ld`:** `ld` in IDLE, TRL or WAIT writes nothing.
- **FIFO write:**
  - A write is performed when the framer writes and `full`=0.
  - A write attempted while `full`=1 is dropped and sets `ovf`.
  - The framer still advances, so the trailer word count reflects words offered, not words stored.
- **FIFO read:**
  - `rden`=1 with `empty`=0 pops one word.
  - `rden` while empty is ignored: no pop, `dvalid`=0, `dout` holds its value.
- **Simultaneous read and write:**
  - At non-full occupancy, both are performed and occupancy is unchanged.
  - When full, the read is performed and the write is dropped (`full` is evaluated before the read).
- **Occupancy counter:** log2(`DEPTH`)+1 bits. Read and write pointers are log2(`DEPTH`) bits and wrap modulo `DEPTH`.
- **Reset values:** `dout`=0, `dvalid`=0, `empty`=1, `full`=0, `ovf`=0, evt=0, err=0, ch=0, pointers=0, state=IDLE.
- **Reset during an event:** the event is discarded and FIFO contents are discarded.

## Timing
- **Header:** written at the first edge where state=IDLE and `start`=1. `empty` falls after that same edge.
- **Data words:** written at the same edge `ld` is sampled. No pipeline.
- **Trailer:** written one cycle after the last data word, or one cycle after the abort edge.
- **Read latency:** `rden` sampled at edge k → `dout` and `dvalid`=1 after edge k. `dvalid` falls after edge k+1 unless `rden` is held with `empty`=0.
- **Streaming reads:** `rden` held high streams one word per cycle. `empty` rises after the edge that pops the last word, so a reader that drops `rden` on `empty` takes no extra pop.
- **Flags:** `empty` and `full` are registered and reflect occupancy after the current edge.
- **Event length:** a full event is `NCH`+2 words, 34 by default. Minimum framer time from `start` to trailer is `NCH`+2 cycles.

## Test plan
- **Reset check:** hold `clr_n`=0 for 2 cycles → `empty`=1, `full`=0, `ovf`=0, `dvalid`=0, `dout`=0.
- **Full event:**
  - Stimulus: `start`↑, then 32 consecutive `ld` with `din`=0x00100+i; drain with `rden` held until `empty`.
  - Response: 34 `dvalid` pulses reading 0xA0000000, then 0x1000_0100, 0x1010_0101 … 0x11F0_011F, then 0xF0000020.
  - Afterwards `empty`=1 and `ovf`=0.
- **Abort:**
  - Stimulus: `start`↑, 5 `ld`, then `start`↓ coinciding with a 6th `ld`.
  - Response: 7 words; the trailer is 0xF1000005. The next event header carries evt=1.
- **Overflow:** with `DEPTH`=64, run 2 events without reading → the last 4 words are dropped, `full`=1 and `ovf`=1. Drain → 64 words; `ovf` stays 1 until `clr_n`.
- **Gapped reads and empty reads:**
  - Stimulus: `ld` every 3rd cycle while `rden` toggles each cycle; also `rden` pulses on an empty FIFO.
  - Response: no lost or duplicated word; the word sequence matches the full-event case; reads on empty give no `dvalid` and leave `dout` unchanged.
- **Pointer and counter wrap:**
  - Stimulus: 3 back-to-back events with concurrent draining; preload evt to 0xFFFF via 65535 short aborted events, or by forcing the counter.
  - Response: pointers wrap cleanly; the header after 0xFFFF shows evt=0x0000.
